// File: rtl/aig_tt_pkg.sv
// Shared types and constants for the AIG truth-table sweeper.
package aig_tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK
  } state_t;

  typedef logic [15:0] tt_t;

  localparam int NUM_MINTERMS = 16;

endpackage

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit word (result 0..16).
module popcount16 (
  input  logic [15:0] bits,
  output logic [4:0]  count
);

  // Sum of the set bits; a plain adder chain is ample for 16 inputs.
  always_comb begin
    count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(bits[i]);
    end
  end

endmodule

// File: rtl/aig_tt_sweep.sv
// Truth-table sweeper for a 4-input, 1-output AIG netlist.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results of the last sweep held on outputs
// RUN   | driving minterm idx on x, sampling y after SETTLE_CYCLES cycles
// CHECK | one cycle: register pass/mismatch_cnt, pulse done, drop busy
module aig_tt_sweep
  import aig_tt_pkg::*;
#(
  parameter tt_t EXPECTED_TT   = 16'h16a9,
  parameter int  SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] x,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [15:0] tt,
  output logic [4:0] mismatch_cnt
);

  // Settle counter runs 0..SETTLE_CYCLES-1; y is sampled on the edge that
  // would take it to SETTLE_CYCLES, i.e. SETTLE_CYCLES edges after x changed.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX    = 4'(NUM_MINTERMS - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  logic [4:0] diff_cnt;

  popcount16 u_popcount (
    .bits  (tt ^ EXPECTED_TT),
    .count (diff_cnt)
  );

  // Sweep FSM; abort outranks everything except reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      x            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      tt           <= '0;
      mismatch_cnt <= '0;
    end else if (abort && (state != IDLE)) begin
      state        <= IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      x            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      tt           <= '0;
      mismatch_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            idx          <= '0;
            settle_cnt   <= '0;
            x            <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            tt           <= '0;
            mismatch_cnt <= '0;
          end
        end
        RUN: begin
          if (settle_cnt == SETTLE_LAST) begin
            tt[idx]    <= y;
            settle_cnt <= '0;
            if (idx == LAST_IDX) begin
              // x stays on the last minterm after the sweep
              state <= CHECK;
            end else begin
              idx <= idx + 4'd1;
              x   <= idx + 4'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          pass         <= (tt == EXPECTED_TT);
          mismatch_cnt <= diff_cnt;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
